// File: rtl/stack_controller.sv
// Stack-region sequencer for PUSH/POP/CALL/RET: owns occupancy count and stack addressing.
// Latency: done two cycles after an accepted req with memAck in the first strobe cycle, one cycle after a rejected req.
// Backpressure: holds memW/memR, memAddr and memWData until memAck; req is only sampled in IDLE, so busy gates new work.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req, op               operation request (00 PUSH, 01 POP, 10 CALL, 11 RET), sampled in IDLE
//   pushData, returnAddr  write data for PUSH / CALL, latched on acceptance
//   flush                 clears occupancy, IDLE only, takes priority over req
//   busy, done, error     status; error qualifies done for overflow/underflow
//   popData               data read by POP/RET, held until the next done
//   fullFlag, emptyFlag   occupancy decode
//   memAddr, memWData, memW, memR, memAck, memRData   stack memory handshake
module stack_controller #(
   parameter int                      DATA_WIDTH = 16,
   parameter int                      ADDR_WIDTH = 16,
   parameter int                      DEPTH      = 8,
   parameter logic [ADDR_WIDTH-1:0]   STACK_BASE = 16'h00F0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] pushData,
   input  logic [DATA_WIDTH-1:0] returnAddr,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] popData,
   output logic                  fullFlag,
   output logic                  emptyFlag,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0] memWData,
   output logic                  memW,
   output logic                  memR,
   input  logic                  memAck,
   input  logic [DATA_WIDTH-1:0] memRData
);

   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_CALL = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   err_q, err_d;
   logic [DATA_WIDTH-1:0]  pop_q, pop_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

   logic                   is_write;
   logic                   full;
   logic                   empty;
   logic [ADDR_WIDTH-1:0]  count_ext;

   // PUSH and CALL both write; POP and RET both read (op[0] selects the direction).
   assign is_write  = (op == OP_PUSH) || (op == OP_CALL);
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count_ext = ADDR_WIDTH'(count_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         err_q   <= 1'b0;
         pop_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= err_d;
         pop_q   <= pop_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      err_d   = err_q;
      pop_d   = pop_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (flush) begin
               count_d = '0;
            end else if (req) begin
               if ((is_write && full) || (!is_write && empty)) begin
                  // Rejected: report straight away, no memory traffic.
                  err_d   = 1'b1;
                  pop_d   = '0;
                  state_d = S_DONE;
               end else if (is_write) begin
                  err_d   = 1'b0;
                  wdata_d = (op == OP_CALL) ? returnAddr : pushData;
                  addr_d  = STACK_BASE + count_ext;
                  state_d = S_WRITE;
               end else begin
                  // Top of stack is the entry just below the next free slot.
                  err_d   = 1'b0;
                  addr_d  = STACK_BASE + count_ext - ADDR_WIDTH'(1);
                  state_d = S_READ;
               end
            end
         end
         S_WRITE: begin
            if (memAck) begin
               count_d = count_q + CW'(1);
               state_d = S_DONE;
            end
         end
         S_READ: begin
            if (memAck) begin
               pop_d   = memRData;
               count_d = count_q - CW'(1);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes decode from state so an asynchronous reset drops them immediately.
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_DONE) && err_q;
   assign memW      = (state_q == S_WRITE);
   assign memR      = (state_q == S_READ);
   assign memAddr   = addr_q;
   assign memWData  = wdata_q;
   assign popData   = pop_q;
   assign fullFlag  = full;
   assign emptyFlag = empty;

endmodule

// File: tb/tb_stack_controller.sv
module tb_stack_controller;

   localparam logic [1:0] PUSH = 2'b00;
   localparam logic [1:0] POP  = 2'b01;
   localparam logic [1:0] CALL = 2'b10;
   localparam logic [1:0] RET  = 2'b11;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] pushData = '0;
   logic [15:0] returnAddr = '0;
   logic        flush = 1'b0;
   logic        busy, done, error;
   logic [15:0] popData;
   logic        fullFlag, emptyFlag;
   logic [15:0] memAddr, memWData;
   logic        memW, memR;
   logic        memAck = 1'b0;
   logic [15:0] memRData = '0;

   stack_controller #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(8), .STACK_BASE(16'h00F0)
   ) dut (
      .clock(clock), .reset(reset), .req(req), .op(op),
      .pushData(pushData), .returnAddr(returnAddr), .flush(flush),
      .busy(busy), .done(done), .error(error), .popData(popData),
      .fullFlag(fullFlag), .emptyFlag(emptyFlag),
      .memAddr(memAddr), .memWData(memWData), .memW(memW), .memR(memR),
      .memAck(memAck), .memRData(memRData)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        err;
      logic [15:0] pop;
      logic        emp;
      logic        ful;
      int          cyc;
   } exp_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] dat;
   } acc_t;

   exp_t sb_q[$];
   acc_t acc_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ack_delay = 0;

   logic [15:0] mem [0:255];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Done monitor: every done cycle must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("done_error",   32'(error),     32'(e.err));
            chk("done_popData", 32'(popData),   32'(e.pop));
            chk("done_cycle",   32'(cyc),       32'(e.cyc));
            chk("done_empty",   32'(emptyFlag), 32'(e.emp));
            chk("done_full",    32'(fullFlag),  32'(e.ful));
         end
      end
   end

   // Memory model: acks after ack_delay stall cycles and checks every access.
   int          stall = 0;
   logic [15:0] cap_addr, cap_wd;
   logic        cap_emp, cap_ful;
   always @(negedge clock) begin
      if (memW && memR) chk("strobe_overlap", 32'd1, 32'd0);
      if (memW || memR) begin
         if (stall == 0) begin
            if (acc_q.size() == 0) begin
               chk("unexpected_access", 32'(memAddr), 32'hFFFF_FFFF);
            end else begin
               acc_t a;
               a = acc_q.pop_front();
               chk("access_dir",  32'(memW),    32'(a.we));
               chk("access_addr", 32'(memAddr), 32'(a.addr));
               if (a.we) chk("access_wdata", 32'(memWData), 32'(a.dat));
            end
            cap_addr = memAddr;
            cap_wd   = memWData;
            cap_emp  = emptyFlag;
            cap_ful  = fullFlag;
         end else begin
            chk("stall_addr",  32'(memAddr),   32'(cap_addr));
            if (memW) chk("stall_wdata", 32'(memWData), 32'(cap_wd));
            chk("stall_busy",  32'(busy),      32'd1);
            chk("stall_empty", 32'(emptyFlag), 32'(cap_emp));
            chk("stall_full",  32'(fullFlag),  32'(cap_ful));
         end
         if (stall >= ack_delay) begin
            memAck   = 1'b1;
            memRData = mem[memAddr[7:0]];
            if (memW) mem[memAddr[7:0]] = memWData;
         end else begin
            memAck = 1'b0;
         end
         stall++;
      end else begin
         memAck = 1'b0;
         stall  = 0;
      end
   end

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 60) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (busy) chk({nm, "_timeout"}, 32'(busy), 32'd0);
   endtask

   // Issues one request and queues the expected result and memory access.
   task automatic do_op(input logic [1:0] o, input logic [15:0] d, input int dly,
                        input logic e_err, input logic [15:0] e_pop, input logic [15:0] e_addr,
                        input logic e_emp, input logic e_ful);
      int   e_edge;
      exp_t e;
      acc_t a;
      ack_delay  = dly;
      op         = o;
      pushData   = (o == PUSH) ? d : 16'hDEAD;
      returnAddr = (o == CALL) ? d : 16'hBEEF;
      if (!e_err) begin
         a.we   = (o == PUSH) || (o == CALL);
         a.addr = e_addr;
         a.dat  = d;
         acc_q.push_back(a);
      end
      req = 1'b1;
      @(posedge clock);
      #1;
      e_edge = cyc;
      // Scramble request inputs to show they were latched.
      req        = 1'b0;
      op         = ~o;
      pushData   = 16'hFFFF;
      returnAddr = 16'hFFFF;
      e.err = e_err;
      e.pop = e_pop;
      e.emp = e_emp;
      e.ful = e_ful;
      e.cyc = e_err ? e_edge : e_edge + 1 + dly;
      sb_q.push_back(e);
      wait_idle("op");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_error",     32'(error),     32'd0);
      chk("rst_popData",   32'(popData),   32'd0);
      chk("rst_memW",      32'(memW),      32'd0);
      chk("rst_memR",      32'(memR),      32'd0);
      chk("rst_memAddr",   32'(memAddr),   32'd0);
      chk("rst_memWData",  32'(memWData),  32'd0);
      chk("rst_empty",     32'(emptyFlag), 32'd1);
      chk("rst_full",      32'(fullFlag),  32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Push two entries and a call frame, then unwind.
      do_op(PUSH, 16'h1111, 0, 1'b0, 16'h0000, 16'h00F0, 1'b0, 1'b0);
      do_op(PUSH, 16'h2222, 0, 1'b0, 16'h0000, 16'h00F1, 1'b0, 1'b0);
      do_op(CALL, 16'h0042, 0, 1'b0, 16'h0000, 16'h00F2, 1'b0, 1'b0);
      do_op(RET,  16'h0000, 0, 1'b0, 16'h0042, 16'h00F2, 1'b0, 1'b0);
      do_op(POP,  16'h0000, 0, 1'b0, 16'h2222, 16'h00F1, 1'b0, 1'b0);
      do_op(POP,  16'h0000, 0, 1'b0, 16'h1111, 16'h00F0, 1'b1, 1'b0);

      // Fill to DEPTH, then overflow.
      for (int i = 0; i < 8; i++)
         do_op(PUSH, 16'hA000 + 16'(i), 0, 1'b0, 16'h1111, 16'h00F0 + 16'(i), 1'b0, (i == 7));
      do_op(PUSH, 16'h9999, 0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);

      // Flush wins over a simultaneous request.
      flush = 1'b1;
      req   = 1'b1;
      op    = PUSH;
      @(posedge clock);
      #1;
      flush = 1'b0;
      req   = 1'b0;
      chk("flush_empty", 32'(emptyFlag), 32'd1);
      chk("flush_full",  32'(fullFlag),  32'd0);
      chk("flush_busy",  32'(busy),      32'd0);

      // Underflow.
      do_op(POP, 16'h0000, 0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);

      // Write stalled for three cycles.
      do_op(PUSH, 16'h5A5A, 3, 1'b0, 16'h0000, 16'h00F0, 1'b0, 1'b0);

      // Reset two cycles into a stalled write.
      begin
         acc_t a;
         a.we = 1'b1; a.addr = 16'h00F1; a.dat = 16'hBEEF;
         acc_q.push_back(a);
      end
      ack_delay = 50;
      op        = PUSH;
      pushData  = 16'hBEEF;
      req       = 1'b1;
      @(posedge clock);
      #1;
      req = 1'b0;
      repeat (2) @(posedge clock);
      #3;
      chk("pre_rst_memW", 32'(memW), 32'd1);
      reset = 1'b0;
      #1;
      chk("midrst_memW",  32'(memW),      32'd0);
      chk("midrst_busy",  32'(busy),      32'd0);
      chk("midrst_empty", 32'(emptyFlag), 32'd1);
      ack_delay = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Normal operation after reset release.
      do_op(PUSH, 16'h7777, 0, 1'b0, 16'h0000, 16'h00F0, 1'b0, 1'b0);
      do_op(POP,  16'h0000, 0, 1'b0, 16'h7777, 16'h00F0, 1'b1, 1'b0);

      repeat (3) @(posedge clock);
      #1;
      chk("sb_drained",  32'(sb_q.size()),  32'd0);
      chk("acc_drained", 32'(acc_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
